// File: rtl/vip_axi4s_types_pkg.sv
// Shared AXI4-Stream width defaults, downsizer state encoding and ratio helpers.
package vip_axi4s_types_pkg;

  localparam int unsigned TDATA_IN_WIDTH_DEF  = 64;
  localparam int unsigned TDATA_OUT_WIDTH_DEF = 16;
  localparam int unsigned TID_WIDTH_DEF       = 2;
  localparam int unsigned TDEST_WIDTH_DEF     = 2;
  localparam int unsigned TUSER_WIDTH_DEF     = 1;

  typedef enum logic {
    EMPTY = 1'b0,
    SEND  = 1'b1
  } ds_state_e;

  function automatic int unsigned ds_ratio(input int unsigned in_w, input int unsigned out_w);
    return (out_w == 0) ? 0 : in_w / out_w;
  endfunction

  // Ratio must be an integer power of two >= 2, and both sides byte-granular.
  function automatic bit ds_ratio_ok(input int unsigned in_w, input int unsigned out_w);
    int unsigned r;
    if (out_w == 0 || (out_w % 8) != 0 || (in_w % out_w) != 0) return 1'b0;
    r = in_w / out_w;
    return (r >= 2) && ((r & (r - 1)) == 0);
  endfunction

endpackage

// File: rtl/vip_axi4s_if.sv
// Plain AXI4-Stream signal bundle used to wire the downsizer in a bench.
interface vip_axi4s_if #(
  parameter int unsigned DATA_W = 64,
  parameter int unsigned ID_W   = 2,
  parameter int unsigned DEST_W = 2,
  parameter int unsigned USER_W = 1
);
  logic                  tvalid;
  logic                  tready;
  logic [DATA_W-1:0]     tdata;
  logic [DATA_W/8-1:0]   tstrb;
  logic [DATA_W/8-1:0]   tkeep;
  logic                  tlast;
  logic [ID_W-1:0]       tid;
  logic [DEST_W-1:0]     tdest;
  logic [USER_W-1:0]     tuser;
endinterface

// File: rtl/axi4s_downsizer.sv
// AXI4-Stream width downsizer: one wide ingress beat is emitted as R narrow
// egress segments, LSB first, trimming trailing null segments on tlast beats.
module axi4s_downsizer
  import vip_axi4s_types_pkg::*;
#(
  parameter int unsigned TDATA_IN_WIDTH_P  = TDATA_IN_WIDTH_DEF,
  parameter int unsigned TDATA_OUT_WIDTH_P = TDATA_OUT_WIDTH_DEF,
  parameter int unsigned TID_WIDTH_P       = TID_WIDTH_DEF,
  parameter int unsigned TDEST_WIDTH_P     = TDEST_WIDTH_DEF,
  parameter int unsigned TUSER_WIDTH_P     = TUSER_WIDTH_DEF
) (
  input  logic                           clk,
  input  logic                           rst_n,
  input  logic                           s_tvalid,
  output logic                           s_tready,
  input  logic [TDATA_IN_WIDTH_P-1:0]    s_tdata,
  input  logic [TDATA_IN_WIDTH_P/8-1:0]  s_tstrb,
  input  logic [TDATA_IN_WIDTH_P/8-1:0]  s_tkeep,
  input  logic                           s_tlast,
  input  logic [TID_WIDTH_P-1:0]         s_tid,
  input  logic [TDEST_WIDTH_P-1:0]       s_tdest,
  input  logic [TUSER_WIDTH_P-1:0]       s_tuser,
  output logic                           m_tvalid,
  input  logic                           m_tready,
  output logic [TDATA_OUT_WIDTH_P-1:0]   m_tdata,
  output logic [TDATA_OUT_WIDTH_P/8-1:0] m_tstrb,
  output logic [TDATA_OUT_WIDTH_P/8-1:0] m_tkeep,
  output logic                           m_tlast,
  output logic [TID_WIDTH_P-1:0]         m_tid,
  output logic [TDEST_WIDTH_P-1:0]       m_tdest,
  output logic [TUSER_WIDTH_P-1:0]       m_tuser
);

  localparam int unsigned R     = ds_ratio(TDATA_IN_WIDTH_P, TDATA_OUT_WIDTH_P);
  localparam int unsigned SEG_W = (R > 2) ? $clog2(R) : 1;
  localparam int unsigned OW    = TDATA_OUT_WIDTH_P;
  localparam int unsigned KO    = TDATA_OUT_WIDTH_P / 8;

  if (!ds_ratio_ok(TDATA_IN_WIDTH_P, TDATA_OUT_WIDTH_P)) begin : g_bad_ratio
    $error("axi4s_downsizer: TDATA_IN_WIDTH_P/TDATA_OUT_WIDTH_P must be a power of two >= 2");
  end

  ds_state_e                        state_q, state_d;
  logic [SEG_W-1:0]                 seg_q, seg_d;
  logic [SEG_W-1:0]                 last_seg_q, last_seg_d;
  logic                             rdy_q;
  logic [TDATA_IN_WIDTH_P-1:0]      data_q;
  logic [TDATA_IN_WIDTH_P/8-1:0]    strb_q, keep_q;
  logic                             tlast_q;
  logic [TID_WIDTH_P-1:0]           id_q;
  logic [TDEST_WIDTH_P-1:0]         dest_q;
  logic [TUSER_WIDTH_P-1:0]         user_q;
  logic                             seg_done;
  logic                             accept;

  assign seg_done = (seg_q == last_seg_q);
  // rdy_q keeps s_tready low through reset and for the release cycle.
  assign s_tready = rdy_q && ((state_q == EMPTY) || (m_tready && seg_done));
  assign accept   = s_tvalid && s_tready;
  assign m_tvalid = (state_q == SEND);
  assign m_tlast  = (state_q == SEND) && tlast_q && seg_done;
  assign m_tid    = id_q;
  assign m_tdest  = dest_q;
  assign m_tuser  = user_q;

  // Final segment of the beat being captured: trailing null segments of a
  // tlast beat are not sent.
  always_comb begin
    last_seg_d = SEG_W'(R - 1);
    if (s_tlast) begin
      last_seg_d = '0;
      for (int unsigned i = 0; i < R; i++) begin
        if (|s_tkeep[i*KO +: KO]) last_seg_d = SEG_W'(i);
      end
    end
  end

  always_comb begin
    state_d = state_q;
    seg_d   = seg_q;
    case (state_q)
      EMPTY: begin
        if (accept) begin
          state_d = SEND;
          seg_d   = '0;
        end
      end
      SEND: begin
        if (m_tready) begin
          if (!seg_done) begin
            seg_d = seg_q + 1'b1;
          end else begin
            seg_d   = '0;
            state_d = accept ? SEND : EMPTY;
          end
        end
      end
      default: begin
        state_d = EMPTY;
        seg_d   = '0;
      end
    endcase
  end

  always_comb begin
    m_tdata = '0;
    m_tstrb = '0;
    m_tkeep = '0;
    for (int unsigned i = 0; i < R; i++) begin
      if (seg_q == SEG_W'(i)) begin
        m_tdata = data_q[i*OW +: OW];
        m_tstrb = strb_q[i*KO +: KO];
        m_tkeep = keep_q[i*KO +: KO];
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= EMPTY;
      seg_q   <= '0;
      rdy_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      seg_q   <= seg_d;
      rdy_q   <= 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (accept) begin
      data_q     <= s_tdata;
      strb_q     <= s_tstrb;
      keep_q     <= s_tkeep;
      tlast_q    <= s_tlast;
      id_q       <= s_tid;
      dest_q     <= s_tdest;
      user_q     <= s_tuser;
      last_seg_q <= last_seg_d;
    end
  end

endmodule

// File: tb/tb_axi4s_downsizer.sv
// Directed self-checking bench for axi4s_downsizer (64 -> 16 bit).
module tb_axi4s_downsizer;

  logic clk = 1'b0;
  logic rst_n;
  int unsigned nvec  = 0;
  int unsigned nfail = 0;

  always #5 clk = ~clk;

  vip_axi4s_if #(.DATA_W(64), .ID_W(2), .DEST_W(2), .USER_W(1)) s_if ();
  vip_axi4s_if #(.DATA_W(16), .ID_W(2), .DEST_W(2), .USER_W(1)) m_if ();

  axi4s_downsizer #(
    .TDATA_IN_WIDTH_P (64),
    .TDATA_OUT_WIDTH_P(16),
    .TID_WIDTH_P      (2),
    .TDEST_WIDTH_P    (2),
    .TUSER_WIDTH_P    (1)
  ) dut (
    .clk     (clk),
    .rst_n   (rst_n),
    .s_tvalid(s_if.tvalid),
    .s_tready(s_if.tready),
    .s_tdata (s_if.tdata),
    .s_tstrb (s_if.tstrb),
    .s_tkeep (s_if.tkeep),
    .s_tlast (s_if.tlast),
    .s_tid   (s_if.tid),
    .s_tdest (s_if.tdest),
    .s_tuser (s_if.tuser),
    .m_tvalid(m_if.tvalid),
    .m_tready(m_if.tready),
    .m_tdata (m_if.tdata),
    .m_tstrb (m_if.tstrb),
    .m_tkeep (m_if.tkeep),
    .m_tlast (m_if.tlast),
    .m_tid   (m_if.tid),
    .m_tdest (m_if.tdest),
    .m_tuser (m_if.tuser)
  );

  typedef struct packed {
    logic [15:0] d;
    logic [1:0]  k;
    logic        l;
    logic [1:0]  id;
    logic [1:0]  dest;
    logic        u;
  } seg_t;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    nvec++;
    assert (obs === exp) else begin
      nfail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic drive(input logic v, input logic [63:0] d, input logic [7:0] k, input logic l,
                       input logic [1:0] id, input logic [1:0] dest, input logic u);
    s_if.tvalid = v;
    s_if.tdata  = d;
    s_if.tkeep  = k;
    s_if.tstrb  = k;
    s_if.tlast  = l;
    s_if.tid    = id;
    s_if.tdest  = dest;
    s_if.tuser  = u;
  endtask

  task automatic expect_beat(input string tag, input logic [15:0] d, input logic [1:0] k,
                             input logic l, input logic [1:0] id, input logic [1:0] dest,
                             input logic u);
    chk({tag, "_valid"}, 64'(m_if.tvalid), 64'd1);
    chk({tag, "_data"},  64'(m_if.tdata),  64'(d));
    chk({tag, "_keep"},  64'(m_if.tkeep),  64'(k));
    chk({tag, "_strb"},  64'(m_if.tstrb),  64'(k));
    chk({tag, "_last"},  64'(m_if.tlast),  64'(l));
    chk({tag, "_side"},  64'({m_if.tid, m_if.tdest, m_if.tuser}), 64'({id, dest, u}));
  endtask

  function automatic logic [63:0] bdata(input int unsigned k);
    logic [63:0] d;
    for (int unsigned j = 0; j < 4; j++) d[j*16 +: 16] = {4'(k), 4'(j), 8'hA5};
    return d;
  endfunction

  function automatic int unsigned exp_last(input logic [7:0] keep, input logic last);
    int unsigned ls;
    if (!last) return 3;
    ls = 0;
    for (int unsigned j = 0; j < 4; j++) if (keep[j*2 +: 2] != 2'b00) ls = j;
    return ls;
  endfunction

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached, observed hang expected finish");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [63:0] d64;
    logic [7:0]  rk [6];
    logic        rl [6];
    seg_t        q[$];
    seg_t        e, held;
    logic        stalled;
    logic        acc;
    int unsigned k, cycles, ls;

    rk = '{8'hFF, 8'h0F, 8'h00, 8'hC3, 8'h30, 8'hFF};
    rl = '{1'b0, 1'b1, 1'b1, 1'b1, 1'b0, 1'b1};

    rst_n = 1'b0;
    m_if.tready = 1'b1;
    drive(1'b0, '0, '0, 1'b0, 2'd0, 2'd0, 1'b0);

    // Reset state
    repeat (2) @(negedge clk);
    #1;
    chk("rst_mvalid", 64'(m_if.tvalid), 64'd0);
    chk("rst_mlast",  64'(m_if.tlast),  64'd0);
    chk("rst_sready", 64'(s_if.tready), 64'd0);
    rst_n = 1'b1;
    #1;
    chk("rel_sready_pre", 64'(s_if.tready), 64'd0);
    @(negedge clk);
    #1;
    chk("rel_sready_post", 64'(s_if.tready), 64'd1);

    // Full non-tlast beat: four segments, one cycle latency
    drive(1'b1, 64'h4444_3333_2222_1111, 8'hFF, 1'b0, 2'd1, 2'd2, 1'b1);
    #1;
    chk("r28_sready_in", 64'(s_if.tready), 64'd1);
    for (int j = 0; j < 4; j++) begin
      @(negedge clk);
      drive(1'b0, '0, '0, 1'b0, 2'd0, 2'd0, 1'b0);
      #1;
      expect_beat($sformatf("r28_s%0d", j), 16'h1111 * 16'(j + 1), 2'b11, 1'b0, 2'd1, 2'd2, 1'b1);
      chk($sformatf("r28_sready%0d", j), 64'(s_if.tready), 64'(j == 3));
    end
    @(negedge clk);
    #1;
    chk("r28_idle", 64'(m_if.tvalid), 64'd0);

    // tlast with keep 0x0F: two segments
    drive(1'b1, 64'h4444_3333_2222_1111, 8'h0F, 1'b1, 2'd3, 2'd1, 1'b0);
    @(negedge clk);
    drive(1'b0, '0, '0, 1'b0, 2'd0, 2'd0, 1'b0);
    #1;
    expect_beat("r29_s0", 16'h1111, 2'b11, 1'b0, 2'd3, 2'd1, 1'b0);
    chk("r29_sready0", 64'(s_if.tready), 64'd0);
    @(negedge clk);
    #1;
    expect_beat("r29_s1", 16'h2222, 2'b11, 1'b1, 2'd3, 2'd1, 1'b0);
    chk("r29_sready1", 64'(s_if.tready), 64'd1);
    @(negedge clk);
    #1;
    chk("r29_idle", 64'(m_if.tvalid), 64'd0);

    // tlast with keep all zero: single null segment
    drive(1'b1, 64'h4444_3333_2222_1111, 8'h00, 1'b1, 2'd2, 2'd3, 1'b1);
    @(negedge clk);
    drive(1'b0, '0, '0, 1'b0, 2'd0, 2'd0, 1'b0);
    #1;
    expect_beat("r30_s0", 16'h1111, 2'b00, 1'b1, 2'd2, 2'd3, 1'b1);
    chk("r30_sready", 64'(s_if.tready), 64'd1);
    @(negedge clk);
    #1;
    chk("r30_idle", 64'(m_if.tvalid), 64'd0);

    // tlast with keep 0xC3: inner null segments still forwarded
    drive(1'b1, 64'hDDDD_CCCC_BBBB_AAAA, 8'hC3, 1'b1, 2'd0, 2'd0, 1'b0);
    @(negedge clk);
    drive(1'b0, '0, '0, 1'b0, 2'd0, 2'd0, 1'b0);
    #1;
    expect_beat("c3_s0", 16'hAAAA, 2'b11, 1'b0, 2'd0, 2'd0, 1'b0);
    @(negedge clk);
    #1;
    expect_beat("c3_s1", 16'hBBBB, 2'b00, 1'b0, 2'd0, 2'd0, 1'b0);
    @(negedge clk);
    #1;
    expect_beat("c3_s2", 16'hCCCC, 2'b00, 1'b0, 2'd0, 2'd0, 1'b0);
    @(negedge clk);
    #1;
    expect_beat("c3_s3", 16'hDDDD, 2'b11, 1'b1, 2'd0, 2'd0, 1'b0);

    // Back-to-back: 8 beats give 32 gapless segments
    for (int c = 0; c <= 32; c++) begin
      @(negedge clk);
      if (c < 32) begin
        k = c / 4;
        drive(1'b1, bdata(k), 8'hFF, k == 7, 2'(k), 2'(k + 1), 1'(k));
      end else begin
        drive(1'b0, '0, '0, 1'b0, 2'd0, 2'd0, 1'b0);
      end
      #1;
      chk($sformatf("b2b_sready%0d", c), 64'(s_if.tready), 64'((c % 4) == 0));
      if (c >= 1) begin
        k = (c - 1) / 4;
        d64 = bdata(k);
        expect_beat($sformatf("b2b_c%0d", c), d64[((c - 1) % 4)*16 +: 16], 2'b11,
                    (k == 7) && (((c - 1) % 4) == 3), 2'(k), 2'(k + 1), 1'(k));
      end
    end
    @(negedge clk);
    #1;
    chk("b2b_idle", 64'(m_if.tvalid), 64'd0);

    // Random backpressure against a segment scoreboard
    k = 0;
    cycles = 0;
    stalled = 1'b0;
    held = '0;
    while (cycles < 400 && !(k == 6 && q.size() == 0)) begin
      @(negedge clk);
      cycles++;
      m_if.tready = 1'($urandom_range(0, 1));
      if (k < 6) drive(1'b1, bdata(k + 8), rk[k], rl[k], 2'(k), 2'(k + 2), 1'(k + 1));
      else       drive(1'b0, '0, '0, 1'b0, 2'd0, 2'd0, 1'b0);
      #1;
      if (m_if.tvalid) begin
        if (stalled) begin
          chk("rnd_hold", 64'({m_if.tdata, m_if.tkeep, m_if.tlast, m_if.tid, m_if.tdest, m_if.tuser}),
              64'(held));
        end
        if (m_if.tready) begin
          stalled = 1'b0;
          if (q.size() == 0) begin
            chk("rnd_extra", 64'(m_if.tvalid), 64'd0);
          end else begin
            e = q.pop_front();
            chk("rnd_data", 64'({m_if.tdata, m_if.tkeep, m_if.tlast, m_if.tid, m_if.tdest, m_if.tuser}),
                64'(e));
          end
        end else begin
          stalled = 1'b1;
          held = {m_if.tdata, m_if.tkeep, m_if.tlast, m_if.tid, m_if.tdest, m_if.tuser};
        end
      end else begin
        if (stalled) chk("rnd_drop", 64'(m_if.tvalid), 64'd1);
        stalled = 1'b0;
      end
      acc = s_if.tvalid && s_if.tready;
      if (acc) begin
        d64 = bdata(k + 8);
        ls = exp_last(rk[k], rl[k]);
        for (int unsigned j = 0; j <= ls; j++) begin
          e.d = d64[j*16 +: 16];
          e.k = rk[k][j*2 +: 2];
          e.l = rl[k] && (j == ls);
          e.id = 2'(k);
          e.dest = 2'(k + 2);
          e.u = 1'(k + 1);
          q.push_back(e);
        end
        k++;
      end
    end
    chk("rnd_complete", 64'((k == 6) && (q.size() == 0)), 64'd1);
    m_if.tready = 1'b1;
    @(negedge clk);
    drive(1'b0, '0, '0, 1'b0, 2'd0, 2'd0, 1'b0);
    @(negedge clk);

    // Reset after the second segment discards the held beat
    drive(1'b1, 64'h4444_3333_2222_1111, 8'hFF, 1'b0, 2'd1, 2'd1, 1'b1);
    @(negedge clk);
    drive(1'b0, '0, '0, 1'b0, 2'd0, 2'd0, 1'b0);
    #1;
    expect_beat("r33_s0", 16'h1111, 2'b11, 1'b0, 2'd1, 2'd1, 1'b1);
    @(negedge clk);
    #1;
    expect_beat("r33_s1", 16'h2222, 2'b11, 1'b0, 2'd1, 2'd1, 1'b1);
    rst_n = 1'b0;
    #1;
    chk("r33_rst_mvalid", 64'(m_if.tvalid), 64'd0);
    chk("r33_rst_sready", 64'(s_if.tready), 64'd0);
    chk("r33_rst_mlast",  64'(m_if.tlast),  64'd0);
    @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    #1;
    chk("r33_post_mvalid", 64'(m_if.tvalid), 64'd0);
    chk("r33_post_sready", 64'(s_if.tready), 64'd1);
    drive(1'b1, 64'h8888_7777_6666_5555, 8'hFF, 1'b1, 2'd2, 2'd0, 1'b0);
    @(negedge clk);
    drive(1'b0, '0, '0, 1'b0, 2'd0, 2'd0, 1'b0);
    #1;
    expect_beat("r33_new_s0", 16'h5555, 2'b11, 1'b0, 2'd2, 2'd0, 1'b0);
    @(negedge clk);
    #1;
    expect_beat("r33_new_s1", 16'h6666, 2'b11, 1'b0, 2'd2, 2'd0, 1'b0);

    $display("== %0d vectors applied, %0d miscompares ==", nvec, nfail);
    $finish;
  end

endmodule
